// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: latches a load/store request, waits a fixed
// number of cycles, then commits the store or returns the aligned word with a one-cycle ack.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  save_method,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        err,
   output logic        busy
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        q_we;
   logic [1:0]  q_sm;
   logic [31:0] q_addr;
   logic [31:0] q_wdata;

   logic [31:0] mem [DEPTH_WORDS];

   logic        cur_we;
   logic [1:0]  cur_sm;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic        bad;
   logic [3:0]  be;
   logic [31:0] wd;
   logic        go_resp;
   logic [IDX_W-1:0] idx;

   // With zero wait states RESP is entered straight from IDLE, so the live
   // inputs are the request; otherwise the latched copy is.
   always_comb begin
      cur_we    = q_we;
      cur_sm    = q_sm;
      cur_addr  = q_addr;
      cur_wdata = q_wdata;
      if (state == S_IDLE) begin
         cur_we    = we;
         cur_sm    = save_method;
         cur_addr  = addr;
         cur_wdata = wdata;
      end
   end

   always_comb begin
      bad = 1'b0;
      be  = 4'b0000;
      wd  = cur_wdata;
      case (cur_sm)
         2'b00: begin
            be = 4'b0001 << cur_addr[1:0];
            wd = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            be  = cur_addr[1] ? 4'b1100 : 4'b0011;
            wd  = {2{cur_wdata[15:0]}};
            bad = cur_addr[0];
         end
         2'b10: begin
            be  = 4'b1111;
            bad = (cur_addr[1:0] != 2'b00);
         end
         default: bad = 1'b1;
      endcase
      if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS))
         bad = 1'b1;
   end

   assign idx     = cur_addr[IDX_W+1:2];
   assign go_resp = ((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                    ((state == S_WAIT) && (cnt == 4'd0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         q_we    <= 1'b0;
         q_sm    <= 2'b00;
         q_addr  <= 32'd0;
         q_wdata <= 32'd0;
         busy    <= 1'b0;
         ack     <= 1'b0;
         err     <= 1'b0;
         rdata   <= 32'd0;
      end else begin
         ack <= go_resp;
         err <= go_resp & bad;
         if (go_resp)
            rdata <= bad ? 32'd0 : mem[idx];
         case (state)
            S_IDLE: begin
               if (req) begin
                  q_we    <= we;
                  q_sm    <= save_method;
                  q_addr  <= addr;
                  q_wdata <= wdata;
                  busy    <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_RESP;
                  end else begin
                     cnt   <= 4'(WAIT_CYCLES - 1);
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0)
                  state <= S_RESP;
               else
                  cnt <= cnt - 4'd1;
            end
            S_RESP: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Array has no reset; contents stay undefined until written.
   always_ff @(posedge clk) begin
      if (go_resp && cur_we && !bad) begin
         for (int b = 0; b < 4; b++)
            if (be[b])
               mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one WAIT_CYCLES=2 instance for the main scenarios and a
// WAIT_CYCLES=0 instance for zero-latency back-to-back traffic.
module tb_data_mem_responder;

   logic        clk;
   logic        rst;
   logic        req, we;
   logic [1:0]  save_method;
   logic [31:0] addr, wdata, rdata;
   logic        ack, err, busy;

   logic        req0, we0;
   logic [1:0]  sm0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        ack0, err0, busy0;

   int vecs  = 0;
   int fails = 0;

   data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .save_method(save_method),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
   );

   data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .we(we0), .save_method(sm0),
      .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One complete access on the WAIT_CYCLES=2 instance; req held until ack.
   // lat counts cycles from the accepting edge to the ack cycle.
   task automatic access(input logic w, input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic e,
                         output int lat, output logic busy_ok, output logic busy_after);
      @(negedge clk);
      req = 1'b1; we = w; save_method = sm; addr = a; wdata = d;
      @(posedge clk); #1;
      lat = 0; busy_ok = 1'b1; rd = 32'hxxxxxxxx; e = 1'bx;
      for (int i = 0; i < 20; i++) begin
         lat++;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (ack === 1'b1) begin
            rd = rdata; e = err;
            break;
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
      @(posedge clk); #1;
      busy_after = busy;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req = 0; we = 0; save_method = 0; addr = 0; wdata = 0;
      req0 = 0; we0 = 0; sm0 = 0; addr0 = 0; wdata0 = 0;
      repeat (3) @(posedge clk);
      #1;
      vecs++; if (ack !== 1'b0)   begin fails++; $display("FAIL rst_ack: got %b exp 0", ack); end
      vecs++; if (err !== 1'b0)   begin fails++; $display("FAIL rst_err: got %b exp 0", err); end
      vecs++; if (busy !== 1'b0)  begin fails++; $display("FAIL rst_busy: got %b exp 0", busy); end
      vecs++; if (rdata !== 32'd0) begin fails++; $display("FAIL rst_rdata: got %h exp 0", rdata); end
      vecs++; if (ack0 !== 1'b0 || busy0 !== 1'b0 || rdata0 !== 32'd0)
         begin fails++; $display("FAIL rst_dut0: ack %b busy %b rdata %h exp 0", ack0, busy0, rdata0); end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_word();
      logic [31:0] rd; logic e, bo, ba; int lat;
      access(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, e, lat, bo, ba);
      vecs++; if (lat !== 3)  begin fails++; $display("FAIL word_st_lat: got %0d exp 3", lat); end
      vecs++; if (e !== 1'b0) begin fails++; $display("FAIL word_st_err: got %b exp 0", e); end
      vecs++; if (bo !== 1'b1) begin fails++; $display("FAIL word_st_busy: busy dropped before ack"); end
      vecs++; if (ba !== 1'b0) begin fails++; $display("FAIL word_st_busy_after: got %b exp 0", ba); end
      access(1'b0, 2'b10, 32'h10, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (lat !== 3)  begin fails++; $display("FAIL word_ld_lat: got %0d exp 3", lat); end
      vecs++; if (e !== 1'b0) begin fails++; $display("FAIL word_ld_err: got %b exp 0", e); end
      vecs++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL word_ld_data: got %h exp deadbeef", rd); end
      vecs++; if (ack !== 1'b0) begin fails++; $display("FAIL word_ack_pulse: got %b exp 0", ack); end
   endtask

   task automatic test_lanes();
      logic [31:0] rd; logic e, bo, ba; int lat;
      access(1'b1, 2'b10, 32'h20, 32'h00000000, rd, e, lat, bo, ba);
      access(1'b1, 2'b00, 32'h22, 32'hFFFFFFAB, rd, e, lat, bo, ba);
      vecs++; if (e !== 1'b0) begin fails++; $display("FAIL lane_byte_err: got %b exp 0", e); end
      access(1'b1, 2'b01, 32'h20, 32'hFFFF1234, rd, e, lat, bo, ba);
      vecs++; if (e !== 1'b0) begin fails++; $display("FAIL lane_half_err: got %b exp 0", e); end
      access(1'b0, 2'b10, 32'h20, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (rd !== 32'h00AB1234) begin fails++; $display("FAIL lane_ld: got %h exp 00ab1234", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic e, bo, ba; int lat;
      access(1'b1, 2'b01, 32'h21, 32'h0000FFFF, rd, e, lat, bo, ba);
      vecs++; if (e !== 1'b1 || lat !== 3) begin fails++; $display("FAIL mis_half_err: err %b lat %0d exp 1/3", e, lat); end
      vecs++; if (rd !== 32'd0) begin fails++; $display("FAIL mis_half_rdata: got %h exp 0", rd); end
      access(1'b0, 2'b10, 32'h22, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (e !== 1'b1) begin fails++; $display("FAIL mis_word_err: got %b exp 1", e); end
      vecs++; if (rd !== 32'd0) begin fails++; $display("FAIL mis_word_rdata: got %h exp 0", rd); end
      access(1'b0, 2'b10, 32'h20, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (rd !== 32'h00AB1234 || e !== 1'b0)
         begin fails++; $display("FAIL mis_unchanged: got %h err %b exp 00ab1234/0", rd, e); end
      access(1'b0, 2'b10, 32'h100, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (e !== 1'b1) begin fails++; $display("FAIL range_err: got %b exp 1", e); end
      vecs++; if (rd !== 32'd0) begin fails++; $display("FAIL range_rdata: got %h exp 0", rd); end
      access(1'b0, 2'b10, 32'hFC, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (e !== 1'b0) begin fails++; $display("FAIL range_last_err: got %b exp 0", e); end
   endtask

   task automatic test_reserved();
      logic [31:0] rd; logic e, bo, ba; int lat;
      access(1'b1, 2'b10, 32'h30, 32'h12345678, rd, e, lat, bo, ba);
      access(1'b1, 2'b11, 32'h30, 32'hFFFFFFFF, rd, e, lat, bo, ba);
      vecs++; if (e !== 1'b1) begin fails++; $display("FAIL rsvd_err: got %b exp 1", e); end
      access(1'b0, 2'b10, 32'h30, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (rd !== 32'h12345678) begin fails++; $display("FAIL rsvd_unchanged: got %h exp 12345678", rd); end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] rd; logic e, bo, ba; int lat;
      access(1'b1, 2'b10, 32'h54, 32'h77777777, rd, e, lat, bo, ba);
      @(negedge clk);
      req = 1'b1; we = 1'b1; save_method = 2'b10; addr = 32'h50; wdata = 32'h0A0A0A0A;
      @(posedge clk); #1;
      addr = 32'h54; wdata = 32'hFFFFFFFF; save_method = 2'b00;
      lat = 1;
      for (int i = 0; i < 20 && ack !== 1'b1; i++) begin
         @(posedge clk); #1; lat++;
      end
      e = err; req = 1'b0; we = 1'b0;
      vecs++; if (lat !== 3 || e !== 1'b0) begin fails++; $display("FAIL busy_ign_ack: lat %0d err %b exp 3/0", lat, e); end
      @(posedge clk); #1;
      access(1'b0, 2'b10, 32'h50, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (rd !== 32'h0A0A0A0A) begin fails++; $display("FAIL busy_ign_50: got %h exp 0a0a0a0a", rd); end
      access(1'b0, 2'b10, 32'h54, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (rd !== 32'h77777777) begin fails++; $display("FAIL busy_ign_54: got %h exp 77777777", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic e, bo, ba; int lat;
      access(1'b1, 2'b10, 32'h40, 32'h11111111, rd, e, lat, bo, ba);
      @(negedge clk);
      req = 1'b1; we = 1'b1; save_method = 2'b10; addr = 32'h40; wdata = 32'h55555555;
      @(posedge clk); #1;
      vecs++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %b exp 1", busy); end
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      vecs++; if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
         begin fails++; $display("FAIL rmid_async: ack %b busy %b err %b exp 0", ack, busy, err); end
      req = 1'b0; we = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vecs++; if (ack !== 1'b0) begin fails++; $display("FAIL rmid_no_ack: got %b exp 0", ack); end
      @(negedge clk); rst = 1'b1;
      access(1'b0, 2'b10, 32'h40, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (rd !== 32'h11111111) begin fails++; $display("FAIL rmid_data: got %h exp 11111111", rd); end
      access(1'b0, 2'b10, 32'h10, 32'h0, rd, e, lat, bo, ba);
      vecs++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rmid_keep: got %h exp deadbeef", rd); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; sm0 = 2'b10; addr0 = 32'h8; wdata0 = 32'hCAFEF00D;
      @(posedge clk); #1;
      vecs++; if (ack0 !== 1'b1 || err0 !== 1'b0) begin fails++; $display("FAIL b2b_ack1: ack %b err %b exp 1/0", ack0, err0); end
      vecs++; if (busy0 !== 1'b1) begin fails++; $display("FAIL b2b_busy1: got %b exp 1", busy0); end
      we0 = 1'b0; wdata0 = 32'h0;
      @(posedge clk); #1;
      vecs++; if (ack0 !== 1'b0 || busy0 !== 1'b0) begin fails++; $display("FAIL b2b_gap: ack %b busy %b exp 0/0", ack0, busy0); end
      @(posedge clk); #1;
      vecs++; if (ack0 !== 1'b1) begin fails++; $display("FAIL b2b_ack2: got %b exp 1", ack0); end
      vecs++; if (rdata0 !== 32'hCAFEF00D) begin fails++; $display("FAIL b2b_data: got %h exp cafef00d", rdata0); end
      req0 = 1'b0;
      @(posedge clk); #1;
      vecs++; if (ack0 !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b exp 0", ack0); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_lanes();
      test_errors();
      test_reserved();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
